// File: rtl/parity_arbiter_pkg.sv
// parity_arbiter shared definitions.
// Default widths for the shared parity generator.
package parity_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  // Low bit of requester i's word in a packed bus of w-bit words.
  function automatic int slice_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/parity.sv
// Even-parity generator.
// XOR reduction of one word.
module parity #(
  parameter int W = 8
) (
  input  logic [W-1:0] d,
  output logic         p
);

  assign p = ^d;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Owns the rotating priority pointer.
module rr_arbiter
  import parity_arbiter_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] eligible,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt;

  // First eligible index from ptr upward, wrapping.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    win         = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (!grant_valid && eligible[j]) begin
        grant[j]    = 1'b1;
        grant_valid = 1'b1;
        win         = PW'(j);
      end
    end
  end

  assign nxt = (win == PW'(N - 1)) ? '0 : win + 1'b1;

  // Move priority to just past the winner.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (advance && grant_valid)
      ptr <= nxt;
  end

endmodule

// File: rtl/parity_arbiter.sv
// Shared even-parity generator/checker.
// Round-robin over requesters, registered ack.
module parity_arbiter
  import parity_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  input  logic [NUM_REQ-1:0]            chk,
  input  logic [NUM_REQ-1:0]            pbit,
  input  logic                          clr_cnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          par,
  output logic                          err,
  output logic [CNT_WIDTH-1:0]          err_cnt,
  output logic                          busy
);

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic                  gv;
  logic [DATA_WIDTH-1:0] word;
  logic                  p;
  logic                  chk_w;
  logic                  pbit_w;
  logic                  mis;

  assign eligible = req & ~ack;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .eligible    (eligible),
    .advance     (1'b1),
    .grant       (grant),
    .grant_valid (gv)
  );

  // One-hot AND-OR mux of the granted word.
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_REQ; i++)
      word = word |
        (data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] &
         {DATA_WIDTH{grant[i]}});
  end

  parity #(
    .W (DATA_WIDTH)
  ) u_par (
    .d (word),
    .p (p)
  );

  assign chk_w  = |(chk & grant);
  assign pbit_w = |(pbit & grant);
  assign mis    = chk_w & (p ^ pbit_w);

  // Register the completed transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack <= '0;
      par <= 1'b0;
      err <= 1'b0;
    end else if (gv) begin
      ack <= grant;
      par <= p;
      err <= mis;
    end else begin
      ack <= '0;
      par <= 1'b0;
      err <= 1'b0;
    end
  end

  // Saturating mismatch counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)
      err_cnt <= '0;
    else if (gv && mis && (err_cnt != '1))
      err_cnt <= err_cnt + 1'b1;
  end

  assign busy = (|req) | (|ack);

endmodule

// File: tb/tb_parity_arbiter.sv
// parity_arbiter directed bench.
// Two instances: default counter and 2-bit counter.
module tb_parity_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  chk;
  logic [3:0]  pbit;
  logic        clr_cnt;
  logic [3:0]  ack,  ack2;
  logic        par,  par2;
  logic        err,  err2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic        busy, busy2;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  parity_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .chk     (chk),
    .pbit    (pbit),
    .clr_cnt (clr_cnt),
    .ack     (ack),
    .par     (par),
    .err     (err),
    .err_cnt (cnt),
    .busy    (busy)
  );

  parity_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .CNT_WIDTH  (2)
  ) dut2 (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .chk     (chk),
    .pbit    (pbit),
    .clr_cnt (clr_cnt),
    .ack     (ack2),
    .par     (par2),
    .err     (err2),
    .err_cnt (cnt2),
    .busy    (busy2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got === exp)
      npass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b1111;
    data    = 32'h03030303;
    chk     = 4'b0000;
    pbit    = 4'b0000;
    clr_cnt = 1'b0;

    // reset holds everything low
    step();
    check("rst1_ack", 32'(ack), 32'h0);
    check("rst1_par", 32'(par), 32'h0);
    check("rst1_err", 32'(err), 32'h0);
    check("rst1_cnt", 32'(cnt), 32'h0);
    step();
    check("rst2_ack", 32'(ack), 32'h0);
    check("rst2_cnt", 32'(cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);

    // round robin from ptr 0
    rst = 1'b0;
    step();
    check("rr0_ack", 32'(ack), 32'h1);
    check("rr0_par", 32'(par), 32'h0);
    step();
    check("rr1_ack", 32'(ack), 32'h2);
    step();
    check("rr2_ack", 32'(ack), 32'h4);
    step();
    check("rr3_ack", 32'(ack), 32'h8);
    check("rr3_par", 32'(par), 32'h0);
    step();
    check("rr4_ack", 32'(ack), 32'h1);

    // generate on requester 2 alone
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst  = 1'b0;
    req  = 4'b0100;
    data = 32'h00A70000;
    step();
    check("gen_ack", 32'(ack), 32'h4);
    check("gen_par", 32'(par), 32'h1);
    check("gen_err", 32'(err), 32'h0);
    step();
    check("gen_mask", 32'(ack), 32'h0);
    step();
    check("gen_ack2", 32'(ack), 32'h4);
    req = 4'b0000;
    step();
    check("gen_idle", 32'(ack), 32'h0);
    check("gen_busy", 32'(busy), 32'h0);

    // check mode on requester 1
    req  = 4'b0010;
    chk  = 4'b0010;
    data = 32'h00000100;
    pbit = 4'b0000;
    step();
    check("chk_ack", 32'(ack), 32'h2);
    check("chk_err", 32'(err), 32'h1);
    check("chk_cnt", 32'(cnt), 32'h1);
    pbit = 4'b0010;
    step();
    check("chk_mask", 32'(ack), 32'h0);
    step();
    check("chk2_ack", 32'(ack), 32'h2);
    check("chk2_err", 32'(err), 32'h0);
    check("chk2_cnt", 32'(cnt), 32'h1);
    req = 4'b0000;
    step();

    // saturation on the 2-bit counter
    clr_cnt = 1'b1;
    step();
    check("clr_cnt2", 32'(cnt2), 32'h0);
    check("clr_cnt", 32'(cnt), 32'h0);
    clr_cnt = 1'b0;
    req  = 4'b0011;
    chk  = 4'b0011;
    pbit = 4'b0000;
    data = 32'h00000101;
    step();
    check("sat1", 32'(cnt2), 32'h1);
    step();
    check("sat2", 32'(cnt2), 32'h2);
    step();
    check("sat3", 32'(cnt2), 32'h3);
    step();
    check("sat_hold", 32'(cnt2), 32'h3);
    check("sat_wide", 32'(cnt), 32'h4);
    clr_cnt = 1'b1;
    step();
    check("clr_win2", 32'(cnt2), 32'h0);
    check("clr_win", 32'(cnt), 32'h0);
    clr_cnt = 1'b0;
    req = 4'b0000;
    chk = 4'b0000;
    step();

    // reset at the edge requester 3 would win
    req  = 4'b1000;
    chk  = 4'b1000;
    data = 32'h01000000;
    pbit = 4'b0000;
    rst  = 1'b1;
    step();
    check("rmid_ack", 32'(ack), 32'h0);
    check("rmid_cnt", 32'(cnt), 32'h0);
    rst = 1'b0;
    req = 4'b0000;
    chk = 4'b0000;
    step();
    check("rmid_idle", 32'(ack), 32'h0);
    req  = 4'b1111;
    data = 32'h03030303;
    step();
    check("rmid_ptr", 32'(ack), 32'h1);
    check("rmid_cnt2", 32'(cnt), 32'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
